// File: rtl/col_enc_pkg.sv
// Shared definitions for the column encoder and the packet arbiter.
// Packet width, resurrection marker and encoder state encodings.
package col_enc_pkg;

   localparam int unsigned PKT_W         = 16;
   localparam logic [15:0] RESURR_MARKER = 16'h8000;
   localparam int unsigned TS_FLAG_BIT   = 15;

   typedef enum logic [1:0] {
      ENC_IDLE  = 2'd0,
      ENC_SORT  = 2'd1,
      ENC_ZERO  = 2'd2,
      ENC_ALARM = 2'd3
   } enc_state_e;

   typedef enum logic {
      LOCK_FREE = 1'b0,
      LOCK_HELD = 1'b1
   } lock_state_e;

   // Only the exact marker word opens a locked sequence; other timestamp words do not.
   function automatic logic is_marker(input logic [PKT_W-1:0] w);
      return w[TS_FLAG_BIT] && (w == RESURR_MARKER);
   endfunction

endpackage

// File: rtl/col_packet_arbiter_if.sv
// Bundle of column inputs, tagged output stream and overflow status of the arbiter.
interface col_packet_arbiter_if
   import col_enc_pkg::*;
#(
   parameter int unsigned N_COLS = 4
);

   localparam int unsigned COL_W = $clog2(N_COLS);

   logic [N_COLS*PKT_W-1:0] col_dat;
   logic [N_COLS-1:0]       col_vld;
   logic [COL_W+PKT_W-1:0]  out_dat;
   logic                    out_valid;
   logic                    out_ready;
   logic [N_COLS-1:0]       ovf_flags;
   logic                    ovf_clr;
   logic [15:0]             drop_cnt;

   modport master (
      output col_dat, col_vld, out_ready, ovf_clr,
      input  out_dat, out_valid, ovf_flags, drop_cnt
   );

   modport slave (
      input  col_dat, col_vld, out_ready, ovf_clr,
      output out_dat, out_valid, ovf_flags, drop_cnt
   );

endinterface

// File: rtl/col_pkt_fifo.sv
// Per-column packet FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module col_pkt_fifo
   import col_enc_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [PKT_W-1:0] din,
   output logic [PKT_W-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [PKT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (do_push && !do_pop) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (do_pop && !do_push) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/col_packet_arbiter.sv
// Merges per-column packet FIFOs into one tagged stream with round-robin arbitration,
// keeping marker sequences contiguous, plus overflow flags and a saturating drop counter.
module col_packet_arbiter
   import col_enc_pkg::*;
#(
   parameter int unsigned N_COLS       = 4,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned LOCK_TIMEOUT = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   col_packet_arbiter_if.slave bus
);

   localparam int unsigned COL_W  = $clog2(N_COLS);
   localparam int unsigned IDLE_W = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned DC_W   = $clog2(N_COLS + 1);

   logic [N_COLS-1:0] fifo_full, fifo_empty, fifo_pop, fifo_push, drop;
   logic [PKT_W-1:0]  fifo_head [N_COLS];

   for (genvar i = 0; i < N_COLS; i++) begin : g_col
      col_pkt_fifo #(
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (fifo_push[i]),
         .pop   (fifo_pop[i]),
         .din   (bus.col_dat[i*PKT_W +: PKT_W]),
         .dout  (fifo_head[i]),
         .full  (fifo_full[i]),
         .empty (fifo_empty[i])
      );
   end

   lock_state_e            lock_state_q, lock_state_d;
   logic [COL_W-1:0]       lock_id_q, lock_id_d;
   logic [1:0]             lock_left_q, lock_left_d;
   logic [IDLE_W-1:0]      idle_q, idle_d;
   logic [COL_W-1:0]       rr_q, rr_d;
   logic [COL_W+PKT_W-1:0] out_dat_q;
   logic                   out_valid_q;
   logic [N_COLS-1:0]      ovf_flags_q, ovf_flags_d;
   logic [15:0]            drop_cnt_q, drop_cnt_d;

   logic             grant_vld, stage_free, load;
   logic [COL_W-1:0] grant_id, cand;
   logic [PKT_W-1:0] head;

   // Descending scan so the last hit is the first non-empty column after rr.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      cand      = '0;
      if (lock_state_q == LOCK_HELD) begin
         grant_vld = !fifo_empty[lock_id_q];
         grant_id  = lock_id_q;
      end else begin
         for (int k = int'(N_COLS); k >= 1; k--) begin
            cand = COL_W'((int'(rr_q) + k) % int'(N_COLS));
            if (!fifo_empty[cand]) begin
               grant_vld = 1'b1;
               grant_id  = cand;
            end
         end
      end
   end

   assign stage_free = !out_valid_q || bus.out_ready;
   assign load       = stage_free && grant_vld;
   assign head       = fifo_head[grant_id];

   always_comb begin
      fifo_pop = '0;
      if (load) begin
         fifo_pop[grant_id] = 1'b1;
      end
      fifo_push = bus.col_vld & (~fifo_full | fifo_pop);
      drop      = bus.col_vld & fifo_full & ~fifo_pop;
   end

   always_comb begin
      lock_state_d = lock_state_q;
      lock_id_d    = lock_id_q;
      lock_left_d  = lock_left_q;
      idle_d       = idle_q;
      rr_d         = rr_q;
      case (lock_state_q)
         LOCK_FREE: begin
            if (load) begin
               rr_d = grant_id;
               if (is_marker(head)) begin
                  lock_state_d = LOCK_HELD;
                  lock_id_d    = grant_id;
                  lock_left_d  = 2'd2;
                  idle_d       = '0;
               end
            end
         end
         LOCK_HELD: begin
            if (load) begin
               idle_d      = '0;
               lock_left_d = lock_left_q - 2'd1;
               if (lock_left_q == 2'd1) begin
                  lock_state_d = LOCK_FREE;
               end
            end else if (stage_free) begin
               // Free stage without a load while locked means the locked FIFO is empty.
               if (idle_q == IDLE_W'(LOCK_TIMEOUT - 1)) begin
                  lock_state_d = LOCK_FREE;
                  idle_d       = '0;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
         end
         default: lock_state_d = LOCK_FREE;
      endcase
   end

   logic [DC_W-1:0] ndrop;
   logic [15:0]     cnt_base;
   logic [16:0]     cnt_sum;

   // A drop on the same edge as ovf_clr survives the clear.
   always_comb begin
      ndrop = '0;
      for (int i = 0; i < int'(N_COLS); i++) begin
         ndrop = ndrop + DC_W'(drop[i]);
      end
      cnt_base    = bus.ovf_clr ? 16'h0 : drop_cnt_q;
      cnt_sum     = {1'b0, cnt_base} + 17'(ndrop);
      drop_cnt_d  = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      ovf_flags_d = (bus.ovf_clr ? '0 : ovf_flags_q) | drop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_state_q <= LOCK_FREE;
         lock_id_q    <= '0;
         lock_left_q  <= '0;
         idle_q       <= '0;
         rr_q         <= COL_W'(N_COLS - 1);
         out_dat_q    <= '0;
         out_valid_q  <= 1'b0;
         ovf_flags_q  <= '0;
         drop_cnt_q   <= '0;
      end else begin
         lock_state_q <= lock_state_d;
         lock_id_q    <= lock_id_d;
         lock_left_q  <= lock_left_d;
         idle_q       <= idle_d;
         rr_q         <= rr_d;
         ovf_flags_q  <= ovf_flags_d;
         drop_cnt_q   <= drop_cnt_d;
         if (stage_free) begin
            out_valid_q <= load;
            if (load) begin
               out_dat_q <= {grant_id, head};
            end
         end
      end
   end

   assign bus.out_dat   = out_dat_q;
   assign bus.out_valid = out_valid_q;
   assign bus.ovf_flags = ovf_flags_q;
   assign bus.drop_cnt  = drop_cnt_q;

endmodule
